// File: rtl/bulk_in_packetiser_pkg.sv
// bulk_in_packetiser_pkg: shared USB constants and output FSM state encoding
package bulk_in_packetiser_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_READY, ST_SEND} state_e;
    localparam int DEF_MAX_PACKET = 512;
    localparam int DEF_TIMEOUT    = 1024;
    localparam int DEF_FIFO_ABITS = 11;
endpackage

// File: rtl/bulk_in_packetiser_sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO
// ports: clock/reset_n (sync, active-low); wr_en_i/wr_data_i write side;
//        rd_en_i pops, rd_data_o shows head; valid_o not empty; full_o; level_o occupancy
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int ABITS = 11
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             valid_o,
    output logic             full_o,
    output logic [ABITS:0]   level_o
);
    logic [WIDTH-1:0] mem [2**ABITS];
    logic [ABITS:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic             wr, rd;

    always_comb begin
        level_o   = wr_ptr_q - rd_ptr_q;
        valid_o   = level_o != '0;
        full_o    = level_o[ABITS];
        wr        = wr_en_i && !full_o;
        rd        = rd_en_i && valid_o;
        wr_ptr_d  = wr_ptr_q + (ABITS+1)'(wr);
        rd_ptr_d  = rd_ptr_q + (ABITS+1)'(rd);
        rd_data_o = mem[rd_ptr_q[ABITS-1:0]];
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr) mem[wr_ptr_q[ABITS-1:0]] <= wr_data_i;
    end
endmodule

// File: rtl/bulk_in_packetiser.sv
// bulk_in_packetiser: packs a byte stream into bulk IN packets for the USB core
// ports: clock/reset_n (sync, active-low); configured_i gates input and new packets;
//        s_axis_* source bytes; m_axis_* bytes to USB core; blk_in_ready_o packet available;
//        blk_cycle_i endpoint transfer active; level_o FIFO occupancy; pkt_count_o committed packets
module bulk_in_packetiser
    import bulk_in_packetiser_pkg::*;
#(
    parameter int MAX_PACKET = DEF_MAX_PACKET,
    parameter int FIFO_ABITS = DEF_FIFO_ABITS,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                configured_i,
    input  logic                s_axis_tvalid_i,
    output logic                s_axis_tready_o,
    input  logic                s_axis_tlast_i,
    input  logic [7:0]          s_axis_tdata_i,
    output logic                blk_in_ready_o,
    input  logic                blk_cycle_i,
    output logic                m_axis_tvalid_o,
    input  logic                m_axis_tready_i,
    output logic                m_axis_tlast_o,
    output logic [7:0]          m_axis_tdata_o,
    output logic [FIFO_ABITS:0] level_o,
    output logic [FIFO_ABITS:0] pkt_count_o
);
    localparam int CW = $clog2(MAX_PACKET);
    localparam int TW = $clog2(TIMEOUT);
    localparam int LW = FIFO_ABITS + 1;

    logic          hold_valid_q, hold_valid_d, hold_last_q, hold_last_d;
    logic [7:0]    hold_data_q, hold_data_d;
    logic [CW-1:0] byte_cnt_q, byte_cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [LW-1:0] pkt_cnt_q, pkt_cnt_d;
    logic          blk_rdy_q, blk_rdy_d;
    state_e        state_q, state_d;
    logic          accept, timeout_hit, close_last, wr_last, pop;
    logic          fifo_wr, fifo_valid, fifo_full;
    logic [8:0]    fifo_wdata, fifo_rdata;

    sync_fifo #(.WIDTH(9), .ABITS(FIFO_ABITS)) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .wr_en_i   (fifo_wr),
        .wr_data_i (fifo_wdata),
        .rd_en_i   (pop),
        .rd_data_o (fifo_rdata),
        .valid_o   (fifo_valid),
        .full_o    (fifo_full),
        .level_o   (level_o)
    );

    // The hold register lets the final byte of a packet be tagged before it reaches the FIFO.
    always_comb begin
        s_axis_tready_o = reset_n && configured_i && !fifo_full && !hold_last_q;
        accept          = s_axis_tvalid_i && s_axis_tready_o;
        timeout_hit     = hold_valid_q && !accept && !fifo_full && timer_q == TW'(TIMEOUT-1);
        close_last      = hold_valid_q && hold_last_q && !fifo_full;
        fifo_wr         = (accept && hold_valid_q) || close_last || timeout_hit;
        wr_last         = hold_last_q || timeout_hit || byte_cnt_q == CW'(MAX_PACKET-1);
        fifo_wdata      = {wr_last, hold_data_q};
        hold_valid_d    = accept || (hold_valid_q && !fifo_wr);
        hold_last_d     = accept ? s_axis_tlast_i : hold_last_q && !fifo_wr;
        hold_data_d     = accept ? s_axis_tdata_i : hold_data_q;
        byte_cnt_d      = !fifo_wr ? byte_cnt_q : wr_last ? '0 : byte_cnt_q + 1'b1;
        // Saturates while the FIFO is full so the flush fires as soon as space appears.
        timer_d         = (accept || !hold_valid_q || fifo_wr) ? '0 :
                          timer_q == TW'(TIMEOUT-1) ? timer_q : timer_q + 1'b1;
        m_axis_tvalid_o = fifo_valid && blk_cycle_i && state_q == ST_SEND;
        pop             = m_axis_tvalid_o && m_axis_tready_i;
        m_axis_tlast_o  = m_axis_tvalid_o && fifo_rdata[8];
        m_axis_tdata_o  = m_axis_tvalid_o ? fifo_rdata[7:0] : '0;
        pkt_cnt_d       = pkt_cnt_q + LW'(fifo_wr && wr_last) - LW'(pop && fifo_rdata[8]);
        blk_in_ready_o  = blk_rdy_q;
        pkt_count_o     = pkt_cnt_q;
    end

    always_comb begin
        state_d   = state_q;
        state_d   = state_q == ST_IDLE  ? ((pkt_cnt_q != '0 && configured_i) ? ST_READY : ST_IDLE) :
                    state_q == ST_READY ? (blk_cycle_i ? ST_SEND : ST_READY) :
                                          ((pop && fifo_rdata[8]) ? ST_IDLE : ST_SEND);
        blk_rdy_d = state_d != ST_IDLE;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            hold_valid_q <= 1'b0;
            hold_last_q  <= 1'b0;
            hold_data_q  <= '0;
            byte_cnt_q   <= '0;
            timer_q      <= '0;
            pkt_cnt_q    <= '0;
            blk_rdy_q    <= 1'b0;
            state_q      <= ST_IDLE;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_last_q  <= hold_last_d;
            hold_data_q  <= hold_data_d;
            byte_cnt_q   <= byte_cnt_d;
            timer_q      <= timer_d;
            pkt_cnt_q    <= pkt_cnt_d;
            blk_rdy_q    <= blk_rdy_d;
            state_q      <= state_d;
        end
    end
endmodule

// File: tb/tb_bulk_in_packetiser.sv
// tb_bulk_in_packetiser: scoreboard bench with a stream-level packetising model
module tb_bulk_in_packetiser;
    localparam int MAXP = 512;
    localparam int AB   = 11;
    localparam int TO   = 16;

    logic          clock = 1'b0;
    logic          reset_n, configured, s_tvalid, s_tready, s_tlast;
    logic [7:0]    s_tdata;
    logic          blk_ready, blk_cycle, m_tvalid, m_tready, m_tlast;
    logic [7:0]    m_tdata;
    logic [AB:0]   level, pkt_count;

    always #5 clock = ~clock;

    bulk_in_packetiser #(.MAX_PACKET(MAXP), .FIFO_ABITS(AB), .TIMEOUT(TO)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .configured_i    (configured),
        .s_axis_tvalid_i (s_tvalid),
        .s_axis_tready_o (s_tready),
        .s_axis_tlast_i  (s_tlast),
        .s_axis_tdata_i  (s_tdata),
        .blk_in_ready_o  (blk_ready),
        .blk_cycle_i     (blk_cycle),
        .m_axis_tvalid_o (m_tvalid),
        .m_axis_tready_i (m_tready),
        .m_axis_tlast_o  (m_tlast),
        .m_axis_tdata_o  (m_tdata),
        .level_o         (level),
        .pkt_count_o     (pkt_count)
    );

    int         tests = 0, fails = 0;
    logic [8:0] exp_q[$];
    logic [8:0] mon_e;
    bit         pend_v, acc_g;
    logic [7:0] pend_d;
    int         cnt, idle, pops, lasts, pkt_peak;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        pend_v = 0;
        cnt    = 0;
        idle   = 0;
    endtask

    // A packet ends on a source tlast, on reaching MAXP bytes, or when no byte follows within TO cycles.
    task automatic model_step(input bit acc, input logic [7:0] d, input bit l);
        if (acc) begin
            if (pend_v) begin
                exp_q.push_back({1'b0, pend_d});
                cnt++;
            end
            if (l || cnt == MAXP-1) begin
                exp_q.push_back({1'b1, d});
                cnt    = 0;
                pend_v = 0;
            end else begin
                pend_v = 1;
                pend_d = d;
                idle   = 0;
            end
        end else if (pend_v) begin
            idle++;
            if (idle == TO) begin
                exp_q.push_back({1'b1, pend_d});
                cnt    = 0;
                pend_v = 0;
            end
        end
    endtask

    task automatic cyc(input bit v, input logic [7:0] d, input bit l, input bit bc, input bit mr);
        @(negedge clock);
        s_tvalid  = v;
        s_tdata   = d;
        s_tlast   = l;
        blk_cycle = bc;
        m_tready  = mr;
        #1;
        acc_g = v && s_tready;
        model_step(acc_g, d, l);
        if (int'(pkt_count) > pkt_peak) pkt_peak = int'(pkt_count);
        #2;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || pend_v || pkt_count != 0 || level != 0) && n < 4000) begin
            cyc(0, 8'h00, 0, 1, 1);
            n++;
        end
        chk({name, "_drained"}, int'(n < 4000), 1);
        chk({name, "_level0"}, int'(level), 0);
    endtask

    always @(negedge clock) begin
        #2;
        if (m_tvalid && m_tready) begin
            pops++;
            if (m_tlast) lasts++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_beat: got %0h, expected no beat", {m_tlast, m_tdata});
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_beat", int'({m_tlast, m_tdata}), int'(mon_e));
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin
        int p0, l0, first, bad, stalls, n;
        reset_n = 0; configured = 1; s_tvalid = 0; s_tdata = 0; s_tlast = 0;
        blk_cycle = 0; m_tready = 0;
        pops = 0; lasts = 0; pkt_peak = 0;
        model_reset();
        repeat (3) cyc(0, 8'h00, 0, 0, 0);
        chk("rst_tready", int'(s_tready), 0);
        chk("rst_blk_ready", int'(blk_ready), 0);
        chk("rst_m_tvalid", int'(m_tvalid), 0);
        chk("rst_m_tlast", int'(m_tlast), 0);
        chk("rst_m_tdata", int'(m_tdata), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_pkt_count", int'(pkt_count), 0);
        reset_n = 1;
        cyc(0, 8'h00, 0, 0, 0);

        p0 = pops; l0 = lasts; pkt_peak = 0;
        for (int i = 0; i < 1024; i++) cyc(1, 8'(i), 0, 1, 1);
        drain("full");
        chk("full_pops", pops - p0, 1024);
        chk("full_packets", lasts - l0, 2);
        chk("full_peak_range", int'(pkt_peak >= 1 && pkt_peak <= 2), 1);
        chk("full_pkt_end", int'(pkt_count), 0);

        p0 = pops; l0 = lasts; first = 0;
        for (int i = 0; i < 5; i++) cyc(1, 8'(i + 10), 0, 0, 1);
        for (int k = 1; k <= 20; k++) begin
            cyc(0, 8'h00, 0, 0, 1);
            if (blk_ready && first == 0) first = k;
        end
        chk("timeout_ready_window", int'(first >= 17 && first <= 19), 1);
        chk("timeout_pkt_count", int'(pkt_count), 1);
        drain("timeout");
        chk("timeout_pops", pops - p0, 5);
        chk("timeout_packets", lasts - l0, 1);

        p0 = pops; l0 = lasts; stalls = 0;
        for (int i = 1; i <= 110; i++) begin
            n = 0;
            do begin
                cyc(1, 8'(i), i == 100, 1, 1);
                if (!acc_g) stalls++;
                n++;
            end while (!acc_g && n < 10);
        end
        chk("srclast_stalls", stalls, 1);
        drain("srclast");
        chk("srclast_pops", pops - p0, 110);
        chk("srclast_packets", lasts - l0, 2);

        p0 = pops; l0 = lasts; n = 0;
        for (int i = 0; i < 512; i++) cyc(1, 8'(i * 7), 0, 0, 1);
        repeat (20) cyc(0, 8'h00, 0, 0, 1);
        while (pops - p0 < 200 && n < 1000) begin
            cyc(0, 8'h00, 0, 1, 1);
            n++;
        end
        chk("pause_sent_200", pops - p0, 200);
        bad = 0;
        repeat (50) begin
            cyc(0, 8'h00, 0, 0, 1);
            if (m_tvalid) bad++;
        end
        chk("pause_no_valid", bad, 0);
        chk("pause_no_pops", pops - p0, 200);
        chk("pause_blk_ready", int'(blk_ready), 1);
        drain("pause");
        chk("pause_pops", pops - p0, 512);
        chk("pause_packets", lasts - l0, 1);

        p0 = pops; l0 = lasts; n = 0; bad = 0;
        while (n < 2049 && bad < 3000) begin
            cyc(1, 8'($urandom), 0, 0, 1);
            if (acc_g) n++;
            bad++;
        end
        stalls = 0;
        repeat (20) begin
            cyc(1, 8'h99, 0, 0, 1);
            if (!s_tready) stalls++;
        end
        chk("fifo_full_tready_low", stalls, 20);
        chk("fifo_full_level", int'(level), 2048);
        drain("fifo_full");
        chk("fifo_full_pops", pops - p0, 2049);
        chk("fifo_full_packets", lasts - l0, 5);

        cyc(1, 8'hA5, 1, 0, 1);
        repeat (4) cyc(0, 8'h00, 0, 0, 1);
        chk("simul_pre_count", int'(pkt_count), 1);
        chk("simul_pre_ready", int'(blk_ready), 1);
        cyc(1, 8'h5A, 1, 1, 1);
        cyc(0, 8'h00, 0, 1, 1);
        chk("simul_pop_last", int'(m_tvalid && m_tlast), 1);
        chk("simul_mid_count", int'(pkt_count), 1);
        cyc(0, 8'h00, 0, 0, 1);
        chk("simul_post_count", int'(pkt_count), 1);
        drain("simul");

        for (int i = 0; i < 30; i++) cyc(1, 8'(i + 100), i == 29, 0, 1);
        repeat (4) cyc(0, 8'h00, 0, 0, 1);
        p0 = pops; n = 0;
        while (pops - p0 < 10 && n < 100) begin
            cyc(0, 8'h00, 0, 1, 1);
            n++;
        end
        chk("rstsend_in_send", int'(m_tvalid), 1);
        reset_n = 0;
        model_reset();
        cyc(0, 8'h00, 0, 1, 1);
        chk("rstsend_tready", int'(s_tready), 0);
        chk("rstsend_blk_ready", int'(blk_ready), 0);
        chk("rstsend_m_tvalid", int'(m_tvalid), 0);
        chk("rstsend_m_tlast", int'(m_tlast), 0);
        chk("rstsend_m_tdata", int'(m_tdata), 0);
        chk("rstsend_level", int'(level), 0);
        chk("rstsend_pkt_count", int'(pkt_count), 0);
        reset_n = 1;
        cyc(0, 8'h00, 0, 0, 1);
        p0 = pops; l0 = lasts;
        for (int i = 0; i < 3; i++) cyc(1, 8'(i + 200), i == 2, 1, 1);
        drain("postrst");
        chk("postrst_pops", pops - p0, 3);
        chk("postrst_packets", lasts - l0, 1);

        cyc(1, 8'h33, 1, 0, 1);
        cyc(0, 8'h00, 0, 0, 1);
        configured = 0;
        n = 0; bad = 0;
        repeat (20) begin
            cyc(1, 8'h44, 0, 1, 1);
            if (acc_g) n++;
            if (blk_ready) bad++;
        end
        chk("unconf_accepts", n, 0);
        chk("unconf_tready", int'(s_tready), 0);
        chk("unconf_blk_ready", bad, 0);
        chk("unconf_pkt_count", int'(pkt_count), 1);
        cyc(0, 8'h00, 0, 1, 1);
        configured = 1;
        drain("unconf");

        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 49) == 0)
                repeat ($urandom_range(10, 30))
                    cyc(0, 8'h00, 0, $urandom_range(0, 9) < 9, $urandom_range(0, 3) != 0);
            else
                cyc($urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 63) == 0,
                    $urandom_range(0, 9) < 9, $urandom_range(0, 3) != 0);
        end
        drain("random");
        chk("random_pkt_end", int'(pkt_count), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
